// File: rtl/chan_rx_proxy.sv
// chan_rx_proxy: receive-side proxy for a channel-tagged valid/ready stream.
// Words (data + channel_id) are buffered in order in a small FIFO. The head
// word is offered to exactly one of NCH per-channel sinks, and each sink has
// its own valid/ready pair. Delivery is strictly in order, so a stalled head
// blocks every later word. An 8-bit wrapping counter per channel tracks
// delivered words.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   data         - input word
//   channel_id   - destination channel of the input word
//   valid/ready  - input handshake; ready depends on registered state only
//   out_data     - data of the head entry, shared by all channels
//   out_valid    - one-hot; bit k set when the head word targets channel k
//   out_ready    - per-channel sink ready; only the head channel's bit matters
//   fifo_count   - number of occupied entries
//   ch_cnt       - per-channel delivered-word counters, 8 bits per channel
module chan_rx_proxy #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CH_W   = 2,
  localparam int unsigned NCH   = 2 ** CH_W,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [CH_W-1:0]   channel_id,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [NCH*8-1:0]  ch_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FullCount = CNT_W'(DEPTH);

  // Storage and pointers
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [CH_W-1:0]   mem_ch_q   [DEPTH];
  logic [CH_W-1:0]   mem_ch_d   [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        ch_cnt_q [NCH];
  logic [7:0]        ch_cnt_d [NCH];

  logic            not_empty;
  logic [CH_W-1:0] head_ch;
  logic            push;
  logic            pop;

  assign not_empty = (count_q != '0);
  assign head_ch   = mem_ch_q[rd_ptr_q];
  assign out_data  = mem_data_q[rd_ptr_q];

  // No bypass when full: ready looks only at the registered count.
  assign ready = (count_q < FullCount);
  assign push  = valid && ready;

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      out_valid[k] = not_empty && (head_ch == CH_W'(k));
    end
  end

  // out_ready bits of non-head channels are masked off by out_valid.
  assign pop = |(out_valid & out_ready);

  always_comb begin
    mem_data_d = mem_data_q;
    mem_ch_d   = mem_ch_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ch_cnt_d   = ch_cnt_q;

    if (push) begin
      mem_data_d[wr_ptr_q] = data;
      mem_ch_d[wr_ptr_q]   = channel_id;
      // DEPTH is a power of two, so the pointer wraps naturally.
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
    end

    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
      ch_cnt_d[head_ch] = ch_cnt_q[head_ch] + 8'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_ch_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        ch_cnt_q[k] <= '0;
      end
    end else begin
      mem_data_q <= mem_data_d;
      mem_ch_q   <= mem_ch_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ch_cnt_q   <= ch_cnt_d;
    end
  end

  assign fifo_count = count_q;

  always_comb begin
    ch_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_cnt[8*k +: 8] = ch_cnt_q[k];
    end
  end

endmodule
